// File: rtl/fifo_wrr_merge.sv
// N-to-1 stream merger: per-lane FIFOs drained by a weighted round-robin arbiter
// into one registered output; optional packet mode keeps packets contiguous.
module fifo_wrr_merge #(
    parameter int N        = 4,
    parameter int WIDTH    = 256,
    parameter int DEPTH    = 16,
    parameter int WEIGHT_W = 4,
    parameter int PKT_MODE = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N-1:0]                       in_valid,
    output logic [N-1:0]                       in_ready,
    input  logic [N*WIDTH-1:0]                 in_data,
    input  logic [N-1:0]                       in_last,
    input  logic [N*WEIGHT_W-1:0]              weight,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WIDTH-1:0]                   out_data,
    output logic                               out_last,
    output logic [$clog2(N)-1:0]               out_src,
    output logic [N*$clog2(DEPTH+1)-1:0]       lane_count
);
    localparam int SW = $clog2(N);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {ARB_FREE, ARB_LOCKED} arb_t;

    logic [WIDTH:0]      mem    [N][DEPTH];
    logic [AW-1:0]       wr_ptr [N];
    logic [AW-1:0]       rd_ptr [N];
    logic [CW-1:0]       count  [N];
    logic [N-1:0]        push;
    logic [N-1:0]        pop;

    arb_t                state, state_nxt;
    logic [SW-1:0]       owner, owner_nxt;
    logic [SW-1:0]       ptr, ptr_nxt;
    logic [SW-1:0]       sel, scan_idx;
    logic [WEIGHT_W-1:0] credit, credit_nxt;
    logic [WEIGHT_W-1:0] w_sel, cr_eff;
    logic [WIDTH:0]      head;
    logic                sel_ok, load, pop_empties, release_ok;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            in_ready[i]               = !rst && (count[i] != CW'(DEPTH));
            push[i]                   = in_valid[i] && in_ready[i];
            lane_count[i*CW +: CW]    = count[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                count[i]  <= '0;
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++)
            if (push[i]) mem[i][wr_ptr[i]] <= {in_last[i], in_data[i*WIDTH +: WIDTH]};
    end

    // Arbitration: owner while locked, else first non-empty lane from ptr upward
    always_comb begin
        sel      = ptr;
        sel_ok   = 1'b0;
        scan_idx = '0;
        if (state == ARB_LOCKED) begin
            sel    = owner;
            sel_ok = (count[owner] != '0);
        end else begin
            // Descending scan so the smallest offset from ptr is the final winner
            for (int k = N - 1; k >= 0; k--) begin
                scan_idx = SW'((int'(ptr) + k) % N);
                if (count[scan_idx] != '0) begin
                    sel    = scan_idx;
                    sel_ok = 1'b1;
                end
            end
        end

        load        = sel_ok && (!out_valid || out_ready);
        pop         = '0;
        pop[sel]    = load;
        head        = mem[sel][rd_ptr[sel]];
        w_sel       = weight[sel*WEIGHT_W +: WEIGHT_W];
        // A fresh grant behaves as if the first pop already consumed one credit
        cr_eff      = (state == ARB_LOCKED) ? credit :
                      ((w_sel == '0) ? '0 : w_sel - 1'b1);
        pop_empties = (count[sel] == CW'(1)) && !push[sel];
        release_ok  = (cr_eff == '0) || pop_empties;
        if (PKT_MODE != 0) release_ok = release_ok && head[WIDTH];

        state_nxt  = state;
        owner_nxt  = owner;
        ptr_nxt    = ptr;
        credit_nxt = credit;
        if (load) begin
            if (release_ok) begin
                state_nxt  = ARB_FREE;
                ptr_nxt    = (sel == SW'(N - 1)) ? '0 : sel + 1'b1;
                credit_nxt = '0;
            end else begin
                state_nxt  = ARB_LOCKED;
                owner_nxt  = sel;
                credit_nxt = (cr_eff == '0) ? '0 : cr_eff - 1'b1;
            end
        end
    end

    // Arbiter state and output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB_FREE;
            owner     <= '0;
            ptr       <= '0;
            credit    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            ptr    <= ptr_nxt;
            credit <= credit_nxt;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= head[WIDTH-1:0];
                out_last  <= head[WIDTH];
                out_src   <= sel;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fifo_wrr_merge.sv
// Scoreboard bench for fifo_wrr_merge: instance 0 in beat mode, instance 1 in packet mode.
module tb_fifo_wrr_merge;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int D  = 16;
    localparam int WW = 4;
    localparam int SW = $clog2(N);
    localparam int CW = $clog2(D + 1);

    typedef struct packed {
        logic [SW-1:0] src;
        logic          last;
        logic [W-1:0]  data;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     in_valid   [2];
    logic [N-1:0]     in_ready   [2];
    logic [N*W-1:0]   in_data    [2];
    logic [N-1:0]     in_last    [2];
    logic [N*WW-1:0]  weight     [2];
    logic             out_valid  [2];
    logic             out_ready  [2];
    logic [W-1:0]     out_data   [2];
    logic             out_last   [2];
    logic [SW-1:0]    out_src    [2];
    logic [N*CW-1:0]  lane_count [2];

    int    checks = 0;
    int    failures = 0;
    int    acc [2];
    beat_t q0[$];
    beat_t q1[$];
    bit    stalled [2];
    beat_t hold [2];
    int    plen [N];
    logic [15:0] plast [N];
    int    ord[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        fifo_wrr_merge #(.N(N), .WIDTH(W), .DEPTH(D), .WEIGHT_W(WW), .PKT_MODE(g)) u_dut (
            .clk(clk), .rst(rst),
            .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_data(in_data[g]),
            .in_last(in_last[g]), .weight(weight[g]),
            .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_data(out_data[g]),
            .out_last(out_last[g]), .out_src(out_src[g]), .lane_count(lane_count[g])
        );
    end

    function automatic logic [W-1:0] mk_data(int l, int s);
        return W'((l << 12) | (s & 12'hFFF));
    endfunction

    function automatic int qsize(int m);
        return (m == 0) ? q0.size() : q1.size();
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(int m, int l, int s, logic last);
        beat_t e;
        e.src  = SW'(l);
        e.last = last;
        e.data = mk_data(l, s);
        if (m == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic drive_beat(int m, int l, int s, logic last);
        in_valid[m][l]       = 1'b1;
        in_data[m][l*W +: W] = mk_data(l, s);
        in_last[m][l]        = last;
    endtask

    task automatic preload(int m, int base);
        for (int k = 0; k < D; k++) begin
            in_valid[m] = '0;
            for (int l = 0; l < N; l++)
                if (k < plen[l]) drive_beat(m, l, base + k, plast[l][k]);
            if (in_valid[m] == '0) break;
            step();
        end
        in_valid[m] = '0;
    endtask

    // Expected beats follow the hand-derived lane order in ord
    task automatic expect_order(int m, int base);
        int cnt [N];
        for (int l = 0; l < N; l++) cnt[l] = 0;
        foreach (ord[i]) begin
            push_exp(m, ord[i], base + cnt[ord[i]], plast[ord[i]][cnt[ord[i]]]);
            cnt[ord[i]]++;
        end
    endtask

    task automatic wait_drain(int m, int budget);
        int n = 0;
        while (qsize(m) != 0 && n < budget) begin
            step();
            n++;
        end
        step();
        checks++;
        if (qsize(m) != 0) begin
            failures++;
            $display("FAIL drain_dut%0d actual_remaining=%0d required=0", m, qsize(m));
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                stalled[m] = 1'b0;
            end else begin
                if (stalled[m]) begin
                    checks++;
                    if (!out_valid[m] || out_src[m] !== hold[m].src ||
                        out_last[m] !== hold[m].last || out_data[m] !== hold[m].data) begin
                        failures++;
                        $display("FAIL stall_hold dut%0d actual v=%0b src=%0d data=%h required v=1 src=%0d data=%h",
                                 m, out_valid[m], out_src[m], out_data[m], hold[m].src, hold[m].data);
                    end
                end
                if (out_valid[m] && out_ready[m]) begin
                    beat_t e;
                    acc[m]++;
                    checks++;
                    if (qsize(m) == 0) begin
                        failures++;
                        $display("FAIL unexpected_beat dut%0d actual src=%0d data=%h required none",
                                 m, out_src[m], out_data[m]);
                    end else begin
                        e = (m == 0) ? q0.pop_front() : q1.pop_front();
                        if (out_src[m] !== e.src || out_last[m] !== e.last || out_data[m] !== e.data) begin
                            failures++;
                            $display("FAIL beat dut%0d actual src=%0d last=%0b data=%h required src=%0d last=%0b data=%h",
                                     m, out_src[m], out_last[m], out_data[m], e.src, e.last, e.data);
                        end
                    end
                end
                stalled[m]   = out_valid[m] && !out_ready[m];
                hold[m].src  = out_src[m];
                hold[m].last = out_last[m];
                hold[m].data = out_data[m];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        rst = 1'b1;
        for (int m = 0; m < 2; m++) begin
            in_valid[m] = '0; in_data[m] = '0; in_last[m] = '0;
            out_ready[m] = 1'b0; weight[m] = {N{4'd1}};
            acc[m] = 0; stalled[m] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();
        check("in_ready_after_reset_d0", 64'(in_ready[0]), 64'hF);
        check("in_ready_after_reset_d1", 64'(in_ready[1]), 64'hF);
        check("out_valid_after_reset", 64'(out_valid[0]), 64'h0);

        // Latency and asynchronous reset mid-cycle
        drive_beat(0, 2, 0, 1'b1);
        step();
        check("latency_t", 64'(out_valid[0]), 64'h0);
        drive_beat(0, 2, 1, 1'b1);
        step();
        in_valid[0] = '0;
        check("latency_t1", 64'(out_valid[0]), 64'h1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_out_valid", 64'(out_valid[0]), 64'h0);
        check("async_rst_lane_count", 64'(lane_count[0]), 64'h0);
        check("async_rst_in_ready", 64'(in_ready[0]), 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        check("in_ready_after_deassert", 64'(in_ready[0]), 64'hF);

        // Equal weights, beat mode: strict rotation, 16 beats in 16 cycles
        plen  = '{4, 4, 4, 4};
        plast = '{16'h8, 16'h8, 16'h8, 16'h8};
        ord   = '{0,1,2,3, 0,1,2,3, 0,1,2,3, 0,1,2,3};
        expect_order(0, 16'h100);
        preload(0, 16'h100);
        a0 = acc[0];
        out_ready[0] = 1'b1;
        repeat (16) step();
        check("rr_throughput_beats", 64'(acc[0] - a0), 64'd16);
        check("rr_done_out_valid", 64'(out_valid[0]), 64'h0);
        check("rr_queue_empty", 64'(qsize(0)), 64'h0);

        // Weighted {3,1,2,0}: weight 0 acts as 1
        out_ready[0] = 1'b0;
        do_reset();
        weight[0] = {4'd0, 4'd2, 4'd1, 4'd3};
        plen  = '{6, 2, 4, 2};
        plast = '{16'h2A, 16'h2, 16'hA, 16'h2};
        ord   = '{0,0,0,1,2,2,3, 0,0,0,1,2,2,3};
        expect_order(0, 16'h200);
        preload(0, 16'h200);
        out_ready[0] = 1'b1;
        wait_drain(0, 100);

        // Full/empty on lane 0 with the output register already occupied
        out_ready[0] = 1'b0;
        do_reset();
        weight[0] = {N{4'd1}};
        drive_beat(0, 3, 0, 1'b1);
        push_exp(0, 3, 0, 1'b1);
        step();
        in_valid[0] = '0;
        step();
        for (int k = 0; k < 16; k++) begin
            drive_beat(0, 0, 16'h300 + k, k[0]);
            push_exp(0, 0, 16'h300 + k, k[0]);
            step();
        end
        check("full_lane_count", 64'(lane_count[0][CW-1:0]), 64'd16);
        check("full_in_ready", 64'(in_ready[0][0]), 64'h0);
        drive_beat(0, 0, 16'h3FF, 1'b1);
        step();
        check("full_no_write_through", 64'(lane_count[0][CW-1:0]), 64'd16);
        in_valid[0] = '0;
        out_ready[0] = 1'b1;
        step();
        check("pop_in_ready", 64'(in_ready[0][0]), 64'h1);
        check("pop_lane_count", 64'(lane_count[0][CW-1:0]), 64'd15);
        wait_drain(0, 100);

        // Packet lock: lane 1 five-beat packet with a push gap, lane 2 full
        do_reset();
        weight[1] = {4'd1, 4'd1, 4'd2, 4'd1};
        for (int k = 0; k < 5; k++) push_exp(1, 1, 16'h400 + k, k == 4);
        for (int k = 0; k < 16; k++) push_exp(1, 2, 16'h480 + k, 1'b1);
        drive_beat(1, 1, 16'h400, 1'b0);
        step();
        drive_beat(1, 1, 16'h401, 1'b0);
        for (int k = 0; k < 16; k++) begin
            drive_beat(1, 2, 16'h480 + k, 1'b1);
            step();
            in_valid[1][1] = 1'b0;
        end
        in_valid[1] = '0;
        check("pkt_lane2_full", 64'(in_ready[1][2]), 64'h0);
        out_ready[1] = 1'b1;
        step();
        step();
        check("pkt_gap_out_valid", 64'(out_valid[1]), 64'h0);
        check("pkt_lane2_not_served", 64'(lane_count[1][2*CW +: CW]), 64'd16);
        step();
        for (int k = 2; k < 5; k++) begin
            drive_beat(1, 1, 16'h400 + k, k == 4);
            step();
        end
        in_valid[1] = '0;
        wait_drain(1, 100);

        // Random backpressure over preloaded packets
        out_ready[1] = 1'b0;
        do_reset();
        weight[1] = {N{4'd1}};
        plen  = '{3, 3, 3, 2};
        plast = '{16'h6, 16'h4, 16'h7, 16'h2};
        ord   = '{0,0,1,1,1,2,3,3,0,2,2};
        expect_order(1, 16'h500);
        preload(1, 16'h500);
        for (int n = 0; n < 400 && q1.size() != 0; n++) begin
            out_ready[1] = 1'($urandom_range(0, 1));
            step();
        end
        out_ready[1] = 1'b1;
        wait_drain(1, 20);

        check("final_q0_empty", 64'(q0.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_wrr_merge.md
# fifo_wrr_merge

Parametrised N-to-1 stream merger, successor to the plain round-robin FIFO merge. Each input lane has its own DEPTH-entry FIFO. A weighted round-robin arbiter with per-lane burst credits drains the FIFOs into one registered output stream. Optional packet mode keeps multi-beat packets contiguous on the output, delimited by `last`. It sits between N producer streams and a single shared downstream consumer.

## Interface
Parameters:
- N, 4, number of input lanes (≥2)
- WIDTH, 256, data width per beat
- DEPTH, 16, entries per lane FIFO (power of two, ≥2)
- WEIGHT_W, 4, width of each lane weight
- PKT_MODE, 1, 1 = never interleave packets; 0 = beat-level arbitration

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  N  per-lane beat valid
- in_ready  out  N  per-lane FIFO not full
- in_data  in  N×WIDTH  packed per-lane data
- in_last  in  N  per-lane end-of-packet flag
- weight  in  N×WEIGHT_W  per-lane beats per grant; 0 is treated as 1
- out_valid  out  1  output register holds a beat
- out_ready  in  1  consumer accepts the beat
- out_data  out  WIDTH  beat data
- out_last  out  1  end-of-packet flag of the beat
- out_src  out  $clog2(N)  source lane of the beat
- lane_count  out  N×$clog2(DEPTH+1)  per-lane FIFO occupancy

## Operation
- Lane FIFO
  - Stores {last, data}.
  - in_ready[i] = (count[i] != DEPTH), forced 0 while rst is high.
  - Push when in_valid[i] && in_ready[i].
  - Pop only when granted by the arbiter.
  - Push and pop in the same cycle leave count unchanged.
  - No write-through when full.
- Arbiter state: `locked`, `owner`, `ptr`, `credit` (WEIGHT_W bits).
- Unlocked
  - Select the first lane with count != 0, scanning from ptr upward with wrap mod N.
  - On the first pop from that lane: locked = 1, owner = lane, credit = max(weight[lane], 1) − 1. weight is sampled only at this point.
- Locked: each pop from owner decrements credit, saturating at 0.
- Release, PKT_MODE = 0, on a pop when either:
  - credit was already 0, or
  - the owner FIFO becomes empty after the pop.
- Release, PKT_MODE = 1, only on a pop whose last = 1, when either:
  - credit was 0, or
  - the owner FIFO is empty after the pop.
  - A packet that exceeds its credit continues until last.
  - If the owner FIFO empties mid-packet, the lock holds and the arbiter waits; no other lane is served.
- On release: ptr = (owner+1) mod N, locked = 0. The next grant may start on the next cycle.
- Output register
  - Loads when (!out_valid || out_ready) and the selected or owner FIFO is non-empty. A load pops that FIFO.
  - If nothing can be loaded and out_ready is high, out_valid drops to 0.
- Reset values: out_valid 0, out_data 0, out_last 0, out_src 0, all lane_count 0, ptr 0, locked 0, credit 0. FIFO memory is not reset.
- rst asserted mid-packet discards all FIFO contents and any lock immediately.

## Timing
- in_ready and lane_count are registered state (count). out_* come directly from flops.
- Latency: a beat pushed at edge t into an empty lane, with the arbiter free and the output empty, gives out_valid = 1 after edge t+1.
- Throughput is 1 beat/cycle sustained, including across lane switches.
- out_valid, out_data, out_last and out_src are stable while out_valid && !out_ready.
- Beats from one lane leave in push order.
- With PKT_MODE = 1, beats of different lanes never interleave between out_last boundaries.
- rst deassertion needs no special sequencing; first push is allowed on the first edge after release.

## Test plan
- Reset/idle: assert rst asynchronously mid-cycle -> out_valid = 0 and lane_count = 0 immediately; in_ready = all ones one edge after deassert.
- Equal weights, PKT_MODE = 0: N = 4, weight = 1, all lanes preloaded with 4 beats, out_ready = 1 -> out_src sequence 0,1,2,3,0,1,2,3,…, 16 beats in 16 consecutive cycles.
- Weighted: weights {3,1,2,1}, lanes full, PKT_MODE = 0 -> out_src pattern 0,0,0,1,2,2,3 repeating.
- Packet lock: PKT_MODE = 1, lane 1 sends a 5-beat packet at weight 2, with a 3-cycle push gap after beat 2 while lane 2 is full -> out_src = 1 for all 5 beats with an out_valid gap, then lane 2.
- Backpressure: toggle out_ready randomly at 50% -> no out_* change while stalled, no loss, and per-lane order preserved versus a scoreboard.
- Full/empty: push 16 beats to lane 0 with out_ready = 0 -> in_ready[0] = 0 and lane_count[0] = 16 after edge 16. Raise out_ready -> in_ready[0] = 1 the edge after the first pop.
